scoreboard: RTL and testbench
=============================

// Module: scoreboard
// PURPOSE
//  Per-thread register reservation scoreboard for the CGRA core dispatcher.
//  Tracks, for every thread ID (TID), which architectural registers have
//  in-flight writes pending: 32 GPRs, CR = idx 32, PR = idx 33.
//  Flags a collision when a dispatch candidate reads registers still
//  reserved for its TID. Reservations are set at dispatch and cleared on
//  load write-back, which may release one register across many TIDs per cycle.
// PARAMETERS
//  NUM_TIDS   256  number of thread IDs tracked
//  TID_W      8    TID width, clog2(NUM_TIDS)
//  NUM_REGS   34   registers per TID: 0-31 GPR, 32 CR, 33 PR
//  REG_IDX_W  7    width of ld_dest_reg
// PORTS
//  clk             in   1         clock; all state updates on posedge
//  rst             in   1         asynchronous, active-high reset
//  input_regs_map  in   NUM_REGS  bitmap of registers used by current CGRA op
//  rd_tid          in   TID_W     TID checked for collision
//  rd_valid        in   1         collision check enable
//  rsv_tid         in   TID_W     TID whose registers are reserved
//  rsv_valid       in   1         reserve enable; the reserved set is input_regs_map
//  wb_tid_bitmap   in   NUM_TIDS  one bit per TID releasing a register
//  wb_valid        in   1         write-back/release enable
//  ld_dest_reg     in   REG_IDX_W register index released by write-back
//  collision       out  1         combinational collision flag
// BEHAVIOUR
//  - State: table[NUM_TIDS][NUM_REGS] of flops; rst clears all entries to 0.
//  - wb_mask = onehot(ld_dest_reg) when ld_dest_reg < NUM_REGS, else 0.
//  - Per-TID update on posedge, all TIDs in parallel:
//    next[t] = (table[t] & ~(wb_valid & wb_tid_bitmap[t] ? wb_mask : 0))
//              | (rsv_valid && t==rsv_tid ? input_regs_map : 0)
//    Release is applied first, then reservation is ORed in. Reserve and
//    release of the same reg/TID in one cycle leaves the reg reserved (fusion).
//  - Collision is combinational, zero latency, and reads the registered table:
//    collision = rd_valid & ( |(input_regs_map & table[rd_tid])
//                           | (wb_valid & wb_tid_bitmap[rd_tid]) )
//    A write-back to rd_tid in the same cycle always flags a collision
//    (conservative), whatever the register.
//  - Same-cycle reservation does not affect collision (see CONFIGURATION).
//  - rd_valid=0 -> collision=0. During reset, collision=0 (table empty).
//  - Independent rd/rsv/wb ports; rd_tid may equal rsv_tid or a wb TID.
//  - No handshake and no backpressure; every valid is a single-cycle strobe.
//  - Reset mid-operation clears all reservations immediately.
// CONFIGURATION
//  SCOREBOARD_RSV_FWD_EN defined: collision also asserts when
//    rd_valid & rsv_valid & rd_tid==rsv_tid & |(input_regs_map), forwarding a
//    same-cycle reservation.
//  Not defined: collision depends only on table and wb terms as above.
// TESTING
//  1 After reset: rsv tid5 regs{0-3}; next cycle rd tid5 map{1,2} -> collision=1;
//    rd tid5 map{4-7} -> 0.
//  2 wb bitmap bit5, ld_dest_reg=1, rd tid5 map{1} -> collision=1 that cycle;
//    next cycle wb_valid=0, rd tid5 map{1} -> 0.
//  3 tid7 holds {4-7}; rsv tid7 {0-3} plus wb tid7 reg5 same cycle
//    -> rd tid7 {5}=0, rd tid7 {0}=1.
//  4 wb bits 10|11, reg2 -> reg2 cleared in both TIDs; rd tid10 in same cycle -> 1.
//  5 rsv tid20 CR(bit32) -> rd tid20 {32}=1; rsv tid22 PR, then wb tid22 reg33
//    -> PR cleared.
//  6 rsv tid50 all 34 bits -> rd tid50 {0}=1; rd tid100 all bits -> 0;
//    ld_dest_reg=40 -> no release.

Source files
------------

// File: rtl/scoreboard.sv
// Per-thread register reservation scoreboard: one 34-bit reservation row per TID,
// zero-latency collision check. Optional macro SCOREBOARD_RSV_FWD_EN forwards same-cycle reservations.
module scoreboard #(
  parameter int NUM_TIDS  = 256,
  parameter int TID_W     = 8,
  parameter int NUM_REGS  = 34,
  parameter int REG_IDX_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REGS-1:0]  input_regs_map,
  input  logic [TID_W-1:0]     rd_tid,
  input  logic                 rd_valid,
  input  logic [TID_W-1:0]     rsv_tid,
  input  logic                 rsv_valid,
  input  logic [NUM_TIDS-1:0]  wb_tid_bitmap,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] ld_dest_reg,
  output logic                 collision
);

  localparam logic [REG_IDX_W-1:0] REG_LIMIT = REG_IDX_W'(NUM_REGS);
  localparam logic [NUM_REGS-1:0]  ONE_HOT0  = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0]               wb_mask;
  logic [NUM_TIDS-1:0][NUM_REGS-1:0] tbl_rows;
  logic [NUM_REGS-1:0]               rd_row;
  logic                              fwd_hit;

  // Out-of-range destinations (e.g. non-tracked registers) release nothing.
  assign wb_mask = (ld_dest_reg < REG_LIMIT) ? (ONE_HOT0 << ld_dest_reg) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TIDS; gi++) begin : g_tid
      logic [NUM_REGS-1:0] row_reg;
      logic [NUM_REGS-1:0] row_next;
      logic [NUM_REGS-1:0] clr_mask;
      logic [NUM_REGS-1:0] set_mask;

      assign clr_mask = (wb_valid && wb_tid_bitmap[gi]) ? wb_mask : '0;
      assign set_mask = (rsv_valid && (rsv_tid == TID_W'(gi))) ? input_regs_map : '0;
      // Release before reserve so a fused reserve+release keeps the register held.
      assign row_next = (row_reg & ~clr_mask) | set_mask;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          row_reg <= '0;
        end else begin
          row_reg <= row_next;
        end
      end

      assign tbl_rows[gi] = row_reg;
    end
  endgenerate

  assign rd_row = tbl_rows[rd_tid];

`ifdef SCOREBOARD_RSV_FWD_EN
  assign fwd_hit = rsv_valid && (rd_tid == rsv_tid) && (|input_regs_map);
`else
  assign fwd_hit = 1'b0;
`endif

  // A write-back touching rd_tid flags conservatively, whatever the register.
  always_comb begin
    collision = 1'b0;
    if (rd_valid && !rst) begin
      collision = (|(input_regs_map & rd_row))
                | (wb_valid && wb_tid_bitmap[rd_tid])
                | fwd_hit;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: directed scenarios plus randomized traffic
// checked against a per-TID/per-register reservation model.
module tb_scoreboard;

  localparam int NT = 256;
  localparam int NR = 34;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  input_regs_map = '0;
  logic [7:0]     rd_tid = '0;
  logic           rd_valid = 1'b0;
  logic [7:0]     rsv_tid = '0;
  logic           rsv_valid = 1'b0;
  logic [NT-1:0]  wb_tid_bitmap = '0;
  logic           wb_valid = 1'b0;
  logic [6:0]     ld_dest_reg = '0;
  logic           collision;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Model: res[t][r] is 1 while register r of thread t has a pending write.
  bit res [NT][NR];

  scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .input_regs_map (input_regs_map),
    .rd_tid         (rd_tid),
    .rd_valid       (rd_valid),
    .rsv_tid        (rsv_tid),
    .rsv_valid      (rsv_valid),
    .wb_tid_bitmap  (wb_tid_bitmap),
    .wb_valid       (wb_valid),
    .ld_dest_reg    (ld_dest_reg),
    .collision      (collision)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR; r++)
        res[t][r] = 1'b0;
  endfunction

  function automatic bit model_coll(bit rdv, int rdt, logic [NR-1:0] map, bit rsvv, int rsvt,
                                    bit wbv, logic [NT-1:0] bm);
    bit hit = 1'b0;
    if (!rdv) return 1'b0;
    for (int r = 0; r < NR; r++)
      if (map[r] && res[rdt][r]) hit = 1'b1;
    if (wbv && bm[rdt]) hit = 1'b1;
`ifdef SCOREBOARD_RSV_FWD_EN
    if (rsvv && rsvt == rdt && map != '0) hit = 1'b1;
`else
    if (rsvv && rsvt < 0) hit = 1'b1;  // forwarding disabled: never taken
`endif
    return hit;
  endfunction

  function automatic void model_step(logic [NR-1:0] map, bit rsvv, int rsvt,
                                     bit wbv, logic [NT-1:0] bm, int ld);
    if (wbv && ld < NR)
      for (int t = 0; t < NT; t++)
        if (bm[t]) res[t][ld] = 1'b0;
    if (rsvv)
      for (int r = 0; r < NR; r++)
        if (map[r]) res[rsvt][r] = 1'b1;
  endfunction

  // One transaction: drive on negedge, check collision #1 later, model updates at posedge.
  // want >= 0 adds an independent hand-derived expectation.
  task automatic cyc(input string tag, input bit rdv, input int rdt, input logic [NR-1:0] map,
                     input bit rsvv, input int rsvt, input bit wbv, input logic [NT-1:0] bm,
                     input int ld, input int want);
    bit exp;
    @(negedge clk);
    rd_valid = rdv; rd_tid = 8'(rdt); input_regs_map = map;
    rsv_valid = rsvv; rsv_tid = 8'(rsvt);
    wb_valid = wbv; wb_tid_bitmap = bm; ld_dest_reg = 7'(ld);
    #1;
    exp = model_coll(rdv, rdt, map, rsvv, rsvt, wbv, bm);
    check_bit(tag, collision, exp);
    if (want >= 0) check_bit({tag, "_dir"}, collision, want[0]);
    txn++;
    $display("txn %0d %s rd=%0b/%0d map=%h rsv=%0b/%0d wb=%0b ld=%0d coll=%0b",
             txn, tag, rdv, rdt, map, rsvv, rsvt, wbv, ld, collision);
    @(posedge clk);
    model_step(map, rsvv, rsvt, wbv, bm, ld);
  endtask

  function automatic logic [NT-1:0] bit_of(int t);
    logic [NT-1:0] v = '0;
    v[t] = 1'b1;
    return v;
  endfunction

  function automatic logic [NR-1:0] reg_of(int r);
    logic [NR-1:0] v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [NR-1:0] all_regs;
    logic [NT-1:0] none;
    logic [NR-1:0] rmap;
    logic [NT-1:0] rbm;
    all_regs = '1;
    none = '0;
    model_clear();

    // Reset: table empty, collision held low even with a full read.
    repeat (2) @(negedge clk);
    rd_valid = 1'b1; input_regs_map = all_regs; rd_tid = 8'd5;
    #1 check_bit("reset_coll", collision, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rd_valid = 1'b0;

    cyc("rst_empty", 1, 5, all_regs, 0, 0, 0, none, 0, 0);
    cyc("rdv_low", 0, 5, all_regs, 0, 0, 1, bit_of(5), 1, 0);

    // 1: reserve tid5 {0-3}
    cyc("t1_rsv", 0, 0, 34'hF, 1, 5, 0, none, 0, -1);
    cyc("t1_hit", 1, 5, 34'h6, 0, 0, 0, none, 0, 1);
    cyc("t1_miss", 1, 5, 34'hF0, 0, 0, 0, none, 0, 0);
    cyc("t1_othertid", 1, 6, 34'hF, 0, 0, 0, none, 0, 0);

    // 2: write-back to tid5 reg1 flags conservatively, then releases
    cyc("t2_wbsame", 1, 5, reg_of(1), 0, 0, 1, bit_of(5), 1, 1);
    cyc("t2_released", 1, 5, reg_of(1), 0, 0, 0, none, 0, 0);
    cyc("t2_kept", 1, 5, reg_of(2), 0, 0, 0, none, 0, 1);

    // 3: tid7 {4-7}, then reserve {0-3} with release of reg5
    cyc("t3_rsv", 0, 0, 34'hF0, 1, 7, 0, none, 0, -1);
    cyc("t3_mix", 0, 0, 34'hF, 1, 7, 1, bit_of(7), 5, -1);
    cyc("t3_r5", 1, 7, reg_of(5), 0, 0, 0, none, 0, 0);
    cyc("t3_r0", 1, 7, reg_of(0), 0, 0, 0, none, 0, 1);

    // Fusion: reserve and release of the same register in one cycle
    cyc("fuse", 0, 0, reg_of(9), 1, 30, 1, bit_of(30), 9, -1);
    cyc("fuse_rd", 1, 30, reg_of(9), 0, 0, 0, none, 0, 1);

    // 4: multi-TID release of reg2
    cyc("t4_rsv10", 0, 0, reg_of(2), 1, 10, 0, none, 0, -1);
    cyc("t4_rsv11", 0, 0, reg_of(2), 1, 11, 0, none, 0, -1);
    cyc("t4_wb", 1, 10, reg_of(2), 0, 0, 1, bit_of(10) | bit_of(11), 2, 1);
    cyc("t4_rd10", 1, 10, reg_of(2), 0, 0, 0, none, 0, 0);
    cyc("t4_rd11", 1, 11, reg_of(2), 0, 0, 0, none, 0, 0);

    // 5: CR and PR
    cyc("t5_rsvcr", 0, 0, reg_of(32), 1, 20, 0, none, 0, -1);
    cyc("t5_rdcr", 1, 20, reg_of(32), 0, 0, 0, none, 0, 1);
    cyc("t5_rsvpr", 0, 0, reg_of(33), 1, 22, 0, none, 0, -1);
    cyc("t5_rdpr", 1, 22, reg_of(33), 0, 0, 0, none, 0, 1);
    cyc("t5_wbpr", 0, 0, '0, 0, 0, 1, bit_of(22), 33, -1);
    cyc("t5_prclr", 1, 22, reg_of(33), 0, 0, 0, none, 0, 0);

    // 6: full row, untouched TID, out-of-range release
    cyc("t6_rsv", 0, 0, all_regs, 1, 50, 0, none, 0, -1);
    cyc("t6_r0", 1, 50, reg_of(0), 0, 0, 0, none, 0, 1);
    cyc("t6_t100", 1, 100, all_regs, 0, 0, 0, none, 0, 0);
    cyc("t6_wb40", 0, 0, '0, 0, 0, 1, bit_of(50), 40, -1);
    cyc("t6_r33", 1, 50, reg_of(33), 0, 0, 0, none, 0, 1);
    cyc("t6_r0b", 1, 50, reg_of(0), 0, 0, 0, none, 0, 1);
    cyc("t6_t255", 1, 255, all_regs, 0, 0, 0, none, 0, 0);

    // Randomized traffic concentrated on a few TIDs so collisions happen often
    for (int i = 0; i < 400; i++) begin
      rmap = NR'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      rbm = '0;
      for (int k = 0; k < 3; k++) rbm[$urandom_range(0, 7)] = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) rbm[$urandom_range(8, NT - 1)] = 1'b1;
      cyc("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 7), rmap,
          $urandom_range(0, 2) == 0, $urandom_range(0, 7),
          $urandom_range(0, 1) == 1, rbm, $urandom_range(0, 40), -1);
    end

    // Mid-operation reset clears reservations immediately
    cyc("mr_rsv", 0, 0, all_regs, 1, 3, 0, none, 0, -1);
    cyc("mr_pre", 1, 3, all_regs, 0, 0, 0, none, 0, 1);
    @(negedge clk);
    rd_valid = 1'b0; wb_valid = 1'b0; rsv_valid = 1'b0;
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    cyc("mr_post", 1, 3, all_regs, 0, 0, 0, none, 0, 0);
    cyc("mr_post50", 1, 50, all_regs, 0, 0, 0, none, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
